// File: rtl/reset_supervisor_pkg.sv
// reset_supervisor_pkg: shared encodings for the reset supervisor and its bus register
package reset_supervisor_pkg;

    localparam int CAUSE_BTN = 0;
    localparam int CAUSE_WD  = 1;
    localparam int CAUSE_SW  = 2;

    localparam int REQ_BIT = 0;
    localparam int CLR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_CLR
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button and emits one event per debounced press
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic level,
    output logic evt
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_TICKS);

    logic meta;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser, then count ticks while held; the counter parks at LIMIT until release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            meta  <= btn_in;
            level <= meta;
            cnt   <= !level ? '0 : (tick && cnt != LIMIT) ? cnt + 1'b1 : cnt;
            evt   <= level && tick && cnt == LIMIT - 1'b1;
        end
    end

endmodule

// File: rtl/reset_supervisor.sv
// reset_supervisor: merges watchdog, button and software resets into a stretched sys_rst
module reset_supervisor
    import reset_supervisor_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        stb,
    input  logic        we,
    input  logic [7:0]  data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        wd_trig,
    input  logic        btn_in,
    output logic        sys_rst
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    count;
    logic [2:0]    cause;
    logic [2:0]    src;
    logic          btn_level;
    logic          btn_evt;
    logic          sw_req;
    logic          clr_req;
    logic          fire;

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .btn_in (btn_in),
        .level  (btn_level),
        .evt    (btn_evt)
    );

    assign sw_req   = stb & we & data_in[REQ_BIT];
    assign clr_req  = stb & we & data_in[CLR_BIT];
    assign fire     = (state == IDLE) && (|src);
    assign ack      = stb;
    assign data_out = (stb & ~we) ? {16'b0, count, 5'b0, cause} : 32'b0;

    // Collect reset sources into their cause bit positions
    always_comb begin
        src            = '0;
        src[CAUSE_BTN] = btn_evt;
        src[CAUSE_WD]  = wd_trig;
        src[CAUSE_SW]  = sw_req;
    end

    // Reset sequencing: enter HOLD on any source, stretch, then wait for sources to clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
            sys_rst  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_INIT;
                    sys_rst  <= 1'b1;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt <= HW'(1)) state <= WAIT_CLR;
                end
                WAIT_CLR: if (!wd_trig && !btn_level) begin
                    state   <= IDLE;
                    sys_rst <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cause/count survive sys_rst; an accepted event overrides a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause <= '0;
            count <= '0;
        end else if (fire) begin
            cause <= src;
            count <= clr_req ? 8'd1 : (count == 8'hFF) ? count : count + 1'b1;
        end else if (clr_req) begin
            cause <= '0;
            count <= '0;
        end
    end

endmodule
